// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared types and constants for the dual-issue memory scheduler
package mem_sched_pkg;

   typedef enum logic [0:0] {
      PASS   = 1'b0,
      SECOND = 1'b1
   } sched_state_t;

   // Byte offset bits dropped when comparing word addresses
   localparam int WORD_LSB = 2;

endpackage

// File: rtl/mem_conflict_detect.sv
// rtl/mem_conflict_detect.sv - combinational same-word lane conflict check
module mem_conflict_detect
   import mem_sched_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter bit SERIALIZE_ALL = 1'b0
) (
   input  logic              i_req1,
   input  logic              i_req2,
   input  logic              i_we1,
   input  logic              i_we2,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [ADDR_W-1:0] i_addr2,
   output logic              o_conflict
);

   logic w_same_word;
   logic w_any_write;

   assign w_same_word = (i_addr1[ADDR_W-1:WORD_LSB] == i_addr2[ADDR_W-1:WORD_LSB]);
   assign w_any_write = i_we1 | i_we2;
   // Two loads of one word share the port safely unless the memory is single-ported
   assign o_conflict  = i_req1 & i_req2 & (SERIALIZE_ALL | (w_same_word & w_any_write));

endmodule

// File: rtl/mem_dual_issue_scheduler.sv
// rtl/mem_dual_issue_scheduler.sv - serializes conflicting M-stage lane pairs onto the dual-port data memory
module mem_dual_issue_scheduler
   import mem_sched_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter bit SERIALIZE_ALL = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemReqM1,
   input  logic              MemReqM2,
   input  logic              MemWriteM1,
   input  logic              MemWriteM2,
   input  logic [2:0]        AddressingControlM1,
   input  logic [2:0]        AddressingControlM2,
   input  logic [ADDR_W-1:0] ALUResultM1,
   input  logic [ADDR_W-1:0] ALUResultM2,
   input  logic [ADDR_W-1:0] WriteDataM1,
   input  logic [ADDR_W-1:0] WriteDataM2,
   output logic [ADDR_W-1:0] A1,
   output logic [ADDR_W-1:0] A2,
   output logic              WE1,
   output logic              WE2,
   output logic [ADDR_W-1:0] WD1,
   output logic [ADDR_W-1:0] WD2,
   output logic [2:0]        AC1,
   output logic [2:0]        AC2,
   input  logic [ADDR_W-1:0] RD1,
   input  logic [ADDR_W-1:0] RD2,
   output logic [ADDR_W-1:0] ReadDataM1,
   output logic [ADDR_W-1:0] ReadDataM2,
   output logic              StallM,
   output logic [ADDR_W-1:0] ConflictCount
);

   sched_state_t      r_state;
   sched_state_t      w_state_nxt;
   logic [ADDR_W-1:0] r_hold;
   logic [ADDR_W-1:0] r_count;
   logic              w_conflict;
   logic              w_we1_lane;
   logic              w_we2_lane;

   mem_conflict_detect #(
      .ADDR_W        (ADDR_W),
      .SERIALIZE_ALL (SERIALIZE_ALL)
   ) u_detect (
      .i_req1     (MemReqM1),
      .i_req2     (MemReqM2),
      .i_we1      (MemWriteM1),
      .i_we2      (MemWriteM2),
      .i_addr1    (ALUResultM1),
      .i_addr2    (ALUResultM2),
      .o_conflict (w_conflict)
   );

   assign w_we1_lane    = MemWriteM1 & MemReqM1;
   assign w_we2_lane    = MemWriteM2 & MemReqM2;
   assign ConflictCount = r_count;

   always_comb begin
      w_state_nxt = r_state;
      A1          = ALUResultM1;
      WD1         = WriteDataM1;
      AC1         = AddressingControlM1;
      A2          = ALUResultM2;
      WD2         = WriteDataM2;
      AC2         = AddressingControlM2;
      WE1         = 1'b0;
      WE2         = 1'b0;
      ReadDataM1  = RD1;
      ReadDataM2  = RD2;
      StallM      = 1'b0;
      case (r_state)
         PASS: begin
            WE1 = w_we1_lane;
            if (w_conflict) begin
               StallM      = 1'b1;
               w_state_nxt = SECOND;
            end else begin
               WE2 = w_we2_lane;
            end
         end
         SECOND: begin
            // Lane 1 already completed; its load result was captured in r_hold
            WE2         = w_we2_lane;
            ReadDataM1  = r_hold;
            w_state_nxt = PASS;
         end
         default: w_state_nxt = PASS;
      endcase
      // No write or stall may escape while reset is held, whatever the lanes present
      if (!rst_n) begin
         WE1    = 1'b0;
         WE2    = 1'b0;
         StallM = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= PASS;
         r_hold  <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == PASS && w_conflict) begin
            r_hold <= RD1;
            if (r_count != '1) begin
               r_count <= r_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_dual_issue_scheduler.sv
// tb/tb_mem_dual_issue_scheduler.sv - scoreboard bench for mem_dual_issue_scheduler
module tb_mem_dual_issue_scheduler;
   import mem_sched_pkg::*;

   typedef struct {
      string       tag;
      bit          inst;
      logic        stall;
      logic        we1;
      logic        we2;
      bit          chk_rd1;
      bit          chk_rd2;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_init;
   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   logic [31:0] mem [0:255];

   // main instance (SERIALIZE_ALL=0)
   logic        req1, req2, wr1, wr2;
   logic [2:0]  ac1_i, ac2_i;
   logic [31:0] addr1, addr2, wdat1, wdat2;
   logic [31:0] A1, A2, WD1, WD2, RD1, RD2, ReadDataM1, ReadDataM2, ConflictCount;
   logic        WE1, WE2, StallM;
   logic [2:0]  AC1, AC2;

   // serialize-all instance
   logic        s_req1, s_req2, s_wr1, s_wr2;
   logic [2:0]  s_ac1_i, s_ac2_i;
   logic [31:0] s_addr1, s_addr2, s_wdat1, s_wdat2;
   logic [31:0] s_A1, s_A2, s_WD1, s_WD2, s_RD1, s_RD2, s_ReadDataM1, s_ReadDataM2, s_ConflictCount;
   logic        s_WE1, s_WE2, s_StallM;
   logic [2:0]  s_AC1, s_AC2;

   always #5 clk = ~clk;

   mem_dual_issue_scheduler #(.ADDR_W(32), .SERIALIZE_ALL(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .MemReqM1(req1), .MemReqM2(req2), .MemWriteM1(wr1), .MemWriteM2(wr2),
      .AddressingControlM1(ac1_i), .AddressingControlM2(ac2_i),
      .ALUResultM1(addr1), .ALUResultM2(addr2), .WriteDataM1(wdat1), .WriteDataM2(wdat2),
      .A1(A1), .A2(A2), .WE1(WE1), .WE2(WE2), .WD1(WD1), .WD2(WD2), .AC1(AC1), .AC2(AC2),
      .RD1(RD1), .RD2(RD2), .ReadDataM1(ReadDataM1), .ReadDataM2(ReadDataM2),
      .StallM(StallM), .ConflictCount(ConflictCount)
   );

   mem_dual_issue_scheduler #(.ADDR_W(32), .SERIALIZE_ALL(1'b1)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .MemReqM1(s_req1), .MemReqM2(s_req2), .MemWriteM1(s_wr1), .MemWriteM2(s_wr2),
      .AddressingControlM1(s_ac1_i), .AddressingControlM2(s_ac2_i),
      .ALUResultM1(s_addr1), .ALUResultM2(s_addr2), .WriteDataM1(s_wdat1), .WriteDataM2(s_wdat2),
      .A1(s_A1), .A2(s_A2), .WE1(s_WE1), .WE2(s_WE2), .WD1(s_WD1), .WD2(s_WD2), .AC1(s_AC1), .AC2(s_AC2),
      .RD1(s_RD1), .RD2(s_RD2), .ReadDataM1(s_ReadDataM1), .ReadDataM2(s_ReadDataM2),
      .StallM(s_StallM), .ConflictCount(s_ConflictCount)
   );

   // Dual-port memory model: combinational read, byte/half/word store at the clock edge
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                         input logic [31:0] d, input logic [2:0] ac);
      logic [31:0] w;
      w = old;
      case (ac[1:0])
         2'b00:   w[8*a[1:0] +: 8] = d[7:0];
         2'b01:   w[16*a[1] +: 16] = d[15:0];
         default: w = d;
      endcase
      return w;
   endfunction

   assign RD1   = mem[A1[9:2]];
   assign RD2   = mem[A2[9:2]];
   assign s_RD1 = mem[s_A1[9:2]];
   assign s_RD2 = mem[s_A2[9:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[8'h40] <= 32'hCAFEF00D;
      end else begin
         if (WE1) mem[A1[9:2]] <= merge(mem[A1[9:2]], A1, WD1, AC1);
         if (WE2) mem[A2[9:2]] <= merge(mem[A2[9:2]], A2, WD2, AC2);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, expv);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare mid-cycle on the falling edge
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (!e.inst) begin
            chk({e.tag, ".stall"}, {31'b0, StallM}, {31'b0, e.stall});
            chk({e.tag, ".we1"}, {31'b0, WE1}, {31'b0, e.we1});
            chk({e.tag, ".we2"}, {31'b0, WE2}, {31'b0, e.we2});
            chk({e.tag, ".cnt"}, ConflictCount, e.cnt);
            if (e.chk_rd1) chk({e.tag, ".rd1"}, ReadDataM1, e.rd1);
            if (e.chk_rd2) chk({e.tag, ".rd2"}, ReadDataM2, e.rd2);
         end else begin
            chk({e.tag, ".s_stall"}, {31'b0, s_StallM}, {31'b0, e.stall});
            chk({e.tag, ".s_we1"}, {31'b0, s_WE1}, {31'b0, e.we1});
            chk({e.tag, ".s_we2"}, {31'b0, s_WE2}, {31'b0, e.we2});
            chk({e.tag, ".s_cnt"}, s_ConflictCount, e.cnt);
            if (e.chk_rd1) chk({e.tag, ".s_rd1"}, s_ReadDataM1, e.rd1);
            if (e.chk_rd2) chk({e.tag, ".s_rd2"}, s_ReadDataM2, e.rd2);
         end
      end
   end

   task automatic expect_out(input string tag, input bit inst, input logic stall,
                             input logic we1, input logic we2, input bit c1, input logic [31:0] r1,
                             input bit c2, input logic [31:0] r2, input logic [31:0] cnt);
      exp_t e;
      e.tag = tag; e.inst = inst; e.stall = stall; e.we1 = we1; e.we2 = we2;
      e.chk_rd1 = c1; e.rd1 = r1; e.chk_rd2 = c2; e.rd2 = r2; e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic r1, input logic w1, input logic [2:0] c1, input logic [31:0] a1,
                        input logic [31:0] d1, input logic r2, input logic w2, input logic [2:0] c2,
                        input logic [31:0] a2, input logic [31:0] d2);
      req1 = r1; wr1 = w1; ac1_i = c1; addr1 = a1; wdat1 = d1;
      req2 = r2; wr2 = w2; ac2_i = c2; addr2 = a2; wdat2 = d2;
   endtask

   task automatic s_drive(input logic r1, input logic [31:0] a1, input logic r2, input logic [31:0] a2);
      s_req1 = r1; s_wr1 = 1'b0; s_ac1_i = 3'b010; s_addr1 = a1; s_wdat1 = 32'h0;
      s_req2 = r2; s_wr2 = 1'b0; s_ac2_i = 3'b010; s_addr2 = a2; s_wdat2 = 32'h0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      mem_init = 1'b1;
      drive(0, 0, 3'b010, 32'h0, 32'h0, 0, 0, 3'b010, 32'h0, 32'h0);
      s_drive(0, 32'h0, 0, 32'h0);
      expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      mem_init = 1'b0;

      // No conflict: LW 0x100 / SW 0x204
      next_cycle();
      drive(1, 0, 3'b010, 32'h100, 32'h0, 1, 1, 3'b010, 32'h204, 32'hAABBCCDD);
      expect_out("noconf", 0, 0, 0, 1, 1, 32'hCAFEF00D, 0, 0, 32'd0);

      // Store -> load same word
      next_cycle();
      drive(1, 1, 3'b010, 32'h100, 32'h12345678, 1, 0, 3'b010, 32'h100, 32'h0);
      expect_out("st_ld_c0", 0, 1, 1, 0, 1, 32'hCAFEF00D, 0, 0, 32'd0);
      next_cycle();
      expect_out("st_ld_c1", 0, 0, 0, 0, 1, 32'hCAFEF00D, 1, 32'h12345678, 32'd1);

      // Load -> store same word
      next_cycle();
      drive(1, 1, 3'b010, 32'h100, 32'h11111111, 0, 0, 3'b010, 32'h0, 32'h0);
      expect_out("preload", 0, 0, 1, 0, 0, 0, 0, 0, 32'd1);
      next_cycle();
      drive(1, 0, 3'b010, 32'h100, 32'h0, 1, 1, 3'b000, 32'h101, 32'h000000FF);
      expect_out("ld_st_c0", 0, 1, 0, 0, 1, 32'h11111111, 0, 0, 32'd1);
      next_cycle();
      expect_out("ld_st_c1", 0, 0, 0, 1, 1, 32'h11111111, 0, 0, 32'd2);
      next_cycle();
      drive(1, 0, 3'b010, 32'h100, 32'h0, 1, 0, 3'b010, 32'h204, 32'h0);
      expect_out("readback", 0, 0, 0, 0, 1, 32'h1111FF11, 1, 32'hAABBCCDD, 32'd2);

      // Two loads, same word
      next_cycle();
      drive(1, 0, 3'b010, 32'h100, 32'h0, 1, 0, 3'b010, 32'h102, 32'h0);
      expect_out("ld_ld", 0, 0, 0, 0, 1, 32'h1111FF11, 1, 32'h1111FF11, 32'd2);
      next_cycle();
      drive(0, 0, 3'b010, 32'h0, 32'h0, 0, 0, 3'b010, 32'h0, 32'h0);
      s_drive(1, 32'h100, 1, 32'h100);
      expect_out("ser_c0", 1, 1, 0, 0, 1, 32'h1111FF11, 0, 0, 32'd0);
      next_cycle();
      expect_out("ser_c1", 1, 0, 0, 0, 1, 32'h1111FF11, 1, 32'h1111FF11, 32'd1);
      next_cycle();
      s_drive(0, 32'h0, 0, 32'h0);
      expect_out("ser_idle", 1, 0, 0, 0, 0, 0, 0, 0, 32'd1);

      // Reset during SECOND of a store/store conflict
      next_cycle();
      drive(1, 1, 3'b010, 32'h108, 32'h55, 1, 1, 3'b010, 32'h108, 32'h66);
      expect_out("rst_c0", 0, 1, 1, 0, 0, 0, 0, 0, 32'd2);
      next_cycle();
      rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(dut.r_state), 32'(PASS));
      chk("rst_hold", dut.r_hold, 32'h0);
      expect_out("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
      next_cycle();
      drive(0, 0, 3'b010, 32'h0, 32'h0, 0, 0, 3'b010, 32'h0, 32'h0);
      rst_n = 1'b1;
      next_cycle();
      chk("rst_mem", mem[8'h42], 32'h00000055);

      // Saturation of the conflict counter; store/store keeps lane 2 data
      force dut.r_count = 32'hFFFFFFFF;
      #1;
      release dut.r_count;
      drive(1, 1, 3'b010, 32'h10C, 32'h1, 1, 1, 3'b010, 32'h10C, 32'h2);
      expect_out("sat_c0", 0, 1, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFF);
      next_cycle();
      expect_out("sat_c1", 0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFFF);
      next_cycle();
      drive(0, 0, 3'b010, 32'h0, 32'h0, 0, 0, 3'b010, 32'h0, 32'h0);
      expect_out("sat_idle", 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF);
      next_cycle();
      chk("st_st_mem", mem[8'h43], 32'h00000002);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) next_cycle();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_dual_issue_scheduler.md
Name: mem_dual_issue_scheduler

Overview:
- Sits between the two M-stage memory lanes of the dual-issue pipeline and the dual-port data memory.
- Detects same-cycle lane conflicts: same word, at least one write.
- On a conflict, serializes the two accesses over two cycles in program order (lane 1 before lane 2) and stalls the pipeline for one cycle.
- Non-conflicting pairs pass straight through with zero added latency.

Parameters:
- ADDR_W, 32, address/data width.
- SERIALIZE_ALL, 0, 1 = serialize any dual access, for use with single-ported memory builds.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- MemReqM1  in  1  lane 1 memory access valid (load or store).
- MemReqM2  in  1  lane 2 memory access valid.
- MemWriteM1  in  1  lane 1 store.
- MemWriteM2  in  1  lane 2 store.
- AddressingControlM1  in  3  lane 1 funct3 size/sign.
- AddressingControlM2  in  3  lane 2 funct3 size/sign.
- ALUResultM1  in  32  lane 1 byte address.
- ALUResultM2  in  32  lane 2 byte address.
- WriteDataM1  in  32  lane 1 store data.
- WriteDataM2  in  32  lane 2 store data.
- A1, A2  out  32  memory port addresses.
- WE1, WE2  out  1  memory port write enables.
- WD1, WD2  out  32  memory port write data.
- AC1, AC2  out  3  memory port addressing control.
- RD1, RD2  in  32  memory port read data (combinational read).
- ReadDataM1  out  32  lane 1 load result.
- ReadDataM2  out  32  lane 2 load result.
- StallM  out  1  hold F/D/E/M pipeline registers.
- ConflictCount  out  32  saturating count of serialized pairs.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low. Reset forces state=PASS, hold register=0, ConflictCount=0.
- Outputs during reset: StallM=0, WE1=WE2=0. A/WD/AC/ReadData follow the PASS combinational rules.
- Conflict detection (combinational):
  - conflict = MemReqM1 & MemReqM2 & (SERIALIZE_ALL | ((ALUResultM1[31:2]==ALUResultM2[31:2]) & (MemWriteM1|MemWriteM2))).
  - Two loads to the same word are never a conflict when SERIALIZE_ALL=0.
- WE gating: WEn = MemWriteMn & MemReqMn in every state where that lane is issued.
- State PASS, no conflict:
  - Port 1 = lane 1 signals; port 2 = lane 2 signals.
  - ReadDataM1=RD1, ReadDataM2=RD2, StallM=0.
- State PASS, conflict:
  - Port 1 = lane 1; port 2 idle (WE2=0, A2/WD2/AC2 = lane 2 values, don't-care).
  - StallM=1.
  - On the clock edge: hold <= RD1, ConflictCount += 1 (saturating at 0xFFFFFFFF), state -> SECOND.
- State SECOND:
  - Upstream holds all M inputs stable because StallM was high the previous cycle.
  - Port 2 = lane 2; port 1 idle (WE1=0).
  - ReadDataM1=hold, ReadDataM2=RD2, StallM=0.
  - Next edge: state -> PASS unconditionally. Conflict is not re-evaluated in SECOND.
- Ordering guarantees (must hold):
  - Store1→load2: load2 sees store1 data, because the store commits at the edge ending cycle 0.
  - Load1→store2: load1 returns the old data.
  - Store1→store2: lane 2 data is final.
- Stall latency is exactly one extra cycle per conflict. Max StallM run length is 1 cycle.
- Reset asserted in SECOND: immediate return to PASS, hold cleared, no write issued while rst_n=0.

Decomposition:
- Shared package mem_sched_pkg:
  - typedef enum {PASS, SECOND} sched_state_t.
  - localparam WORD_LSB=2.
- Optional sub-module mem_conflict_detect: pure combinational conflict function, reusable by the hazard unit.

Test Plan:
- No conflict: lane 1 load 0x100, lane 2 store 0x204 data 0xAABBCCDD → both ports active same cycle, StallM=0, ConflictCount=0.
- Store→load same word: lane 1 SW 0x100 = 0x12345678, lane 2 LW 0x100 → StallM=1 for one cycle, WE2=0 in cycle 0; cycle 1 ReadDataM2=0x12345678, ConflictCount=1.
- Load→store same word: mem[0x100]=0x11111111; lane 1 LW 0x100, lane 2 SB 0x101 = 0xFF → ReadDataM1=0x11111111 (from hold); mem afterwards = 0x1111FF11.
- Two loads same word, SERIALIZE_ALL=0 → no stall. Same stimulus with SERIALIZE_ALL=1 → StallM pulses 1 cycle, both loads return correct data.
- Reset mid-op: assert rst_n=0 during SECOND → StallM=0, WE1=WE2=0, state PASS, hold=0, ConflictCount=0.
- Saturation: preload ConflictCount=0xFFFFFFFF by force, create a conflict → count stays 0xFFFFFFFF.
